pll_lock_sequencer: RTL and testbench

Power-up and recovery controller for the 50 MHz-referenced PLL instance.
- Holds the PLL in reset for a fixed period, then waits for lock with a timeout.
- Qualifies lock as stable, then releases a system reset request.
- On timeout or loss of lock, re-resets the PLL with bounded retries and reports status.
- Runs entirely in the `refclk` domain. The sequencer's PLL reset output drives the PLL reset. The PLL lock output feeds back to `pll_locked`.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and timing defaults for the PLL lock sequencer.
// Holds the FSM state encoding and the timer-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  localparam int DEF_RST_HOLD_CYC     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;  // 1 ms of 50 MHz refclk
  localparam int DEF_STABLE_CYC       = 1024;
  localparam int DEF_MAX_RETRIES      = 3;
  localparam int RETRY_W              = 2;

  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with async active-low clear; 2 cycles of latency.
// No handshake: the input is sampled every cycle.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: hold reset, wait for lock, qualify, release system reset, retry on failure.
// Outputs registered on the transition edge; pll_locked seen 2 cycles late through sync_2ff; no backpressure.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int STABLE_CYC       = DEF_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         loss_cnt
);

  localparam int TMR_W = tmr_width(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as the first qualified cycle.
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'((STABLE_CYC > 1) ? STABLE_CYC - 2 : 0);
  localparam logic [RETRY_W-1:0] RC_MAX = RETRY_W'(MAX_RETRIES);

  if (MAX_RETRIES < 0 || MAX_RETRIES > (1 << RETRY_W) - 1) begin : g_bad_retries
    $error("MAX_RETRIES does not fit in retry_cnt");
  end
  if (RST_HOLD_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || STABLE_CYC < 1) begin : g_bad_timing
    $error("timing parameters must be at least 1");
  end

  logic               lock_s;
  pll_state_t         st_q, st_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RETRY_W-1:0] rc_q, rc_d;
  logic [7:0]         loss_q, loss_d;
  logic               retry;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q;
    rc_d   = rc_q;
    loss_d = loss_q;
    retry  = 1'b0;
    if (restart) begin
      st_d  = ST_RESET;
      tmr_d = '0;
      rc_d  = '0;
    end else begin
      case (st_q)
        ST_RESET: begin
          if (tmr_q == RST_LAST) begin
            st_d  = ST_WAIT_LOCK;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            st_d  = ST_STABLE;
            tmr_d = '0;
          end else if (tmr_q == TO_LAST) begin
            retry = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            retry = 1'b1;
          end else if (tmr_q == STB_LAST) begin
            st_d  = ST_RUN;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            st_d  = ST_RESET;
            tmr_d = '0;
            rc_d  = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAIL: ;
        default: begin
          st_d  = ST_RESET;
          tmr_d = '0;
        end
      endcase
      if (retry) begin
        tmr_d = '0;
        if (rc_q == RC_MAX) begin
          st_d = ST_FAIL;
        end else begin
          st_d = ST_RESET;
          rc_d = rc_q + RETRY_W'(1);
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_RESET;
      tmr_q     <= '0;
      rc_q      <= '0;
      loss_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      st_q      <= st_d;
      tmr_q     <= tmr_d;
      rc_q      <= rc_d;
      loss_q    <= loss_d;
      pll_rst   <= (st_d == ST_RESET) || (st_d == ST_FAIL);
      sys_rst_n <= (st_d == ST_RUN);
      ready     <= (st_d == ST_RUN);
      fail      <= (st_d == ST_FAIL);
    end
  end

  assign state     = st_q;
  assign retry_cnt = rc_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing (hold 4, timeout 20, stable 8, retries 2).
// Vector table for sequencing/timeout/glitch/restart, then hand-written loss, saturation and async-reset sequences.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_chk = 0;
  int n_fail = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYC     (4),
    .LOCK_TIMEOUT_CYC (20),
    .STABLE_CYC       (8),
    .MAX_RETRIES      (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic rst_n, locked, restart;
    int   ticks;
    int   st, prst, srst, rdy, fl, rc, lc;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic l, input logic rs, input int n,
                      input int st, input int pr, input int sr, input int rd,
                      input int fl, input int rc, input int lc);
    vec_t v;
    v.rst_n = r; v.locked = l; v.restart = rs; v.ticks = n;
    v.st = st; v.prst = pr; v.srst = sr; v.rdy = rd; v.fl = fl; v.rc = rc; v.lc = lc;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int lim, input string nm);
    int n;
    n = 0;
    while (!ready && n < lim) begin
      tick();
      n++;
    end
    chk(nm, int'(ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_loss;
    //   rst lk rs ticks st pr sr rd fl rc lc
    addv(0, 0, 0,  2,   0, 1, 0, 0, 0, 0, 0);  // reset values
    addv(1, 0, 0,  3,   0, 1, 0, 0, 0, 0, 0);
    addv(1, 0, 0,  1,   1, 0, 0, 0, 0, 0, 0);  // pll_rst high exactly 4 cycles
    addv(1, 0, 0,  6,   1, 0, 0, 0, 0, 0, 0);
    addv(1, 1, 0,  2,   1, 0, 0, 0, 0, 0, 0);  // lock 6 cycles after pll_rst falls
    addv(1, 1, 0,  1,   2, 0, 0, 0, 0, 0, 0);
    addv(1, 1, 0,  6,   2, 0, 0, 0, 0, 0, 0);
    addv(1, 1, 0,  1,   3, 0, 1, 1, 0, 0, 0);  // ready 8 cycles after lock_s
    addv(1, 0, 0,  2,   3, 0, 1, 1, 0, 0, 0);  // lock drop not yet visible
    addv(1, 0, 0,  1,   0, 1, 0, 0, 0, 0, 1);  // loss in RUN
    addv(1, 0, 0,  3,   0, 1, 0, 0, 0, 0, 1);  // attempt 1 of timeout run
    addv(1, 0, 0,  1,   1, 0, 0, 0, 0, 0, 1);
    addv(1, 0, 0, 19,   1, 0, 0, 0, 0, 0, 1);
    addv(1, 0, 0,  1,   0, 1, 0, 0, 0, 1, 1);  // timeout after 20 cycles
    addv(1, 0, 0,  3,   0, 1, 0, 0, 0, 1, 1);
    addv(1, 0, 0,  1,   1, 0, 0, 0, 0, 1, 1);
    addv(1, 0, 0, 19,   1, 0, 0, 0, 0, 1, 1);
    addv(1, 0, 0,  1,   0, 1, 0, 0, 0, 2, 1);
    addv(1, 0, 0,  3,   0, 1, 0, 0, 0, 2, 1);
    addv(1, 0, 0,  1,   1, 0, 0, 0, 0, 2, 1);
    addv(1, 0, 0, 19,   1, 0, 0, 0, 0, 2, 1);
    addv(1, 0, 0,  1,   4, 1, 0, 0, 1, 2, 1);  // retries exhausted
    addv(1, 0, 0, 10,   4, 1, 0, 0, 1, 2, 1);  // FAIL is sticky
    addv(1, 0, 1,  1,   0, 1, 0, 0, 0, 0, 1);  // restart out of FAIL
    addv(1, 0, 0,  3,   0, 1, 0, 0, 0, 0, 1);
    addv(1, 0, 0,  1,   1, 0, 0, 0, 0, 0, 1);
    addv(1, 1, 0,  3,   2, 0, 0, 0, 0, 0, 1);  // glitch test: into STABLE
    addv(1, 1, 0,  3,   2, 0, 0, 0, 0, 0, 1);
    addv(1, 0, 0,  1,   2, 0, 0, 0, 0, 0, 1);  // one-cycle drop
    addv(1, 1, 0,  1,   2, 0, 0, 0, 0, 0, 1);
    addv(1, 1, 0,  1,   0, 1, 0, 0, 0, 1, 1);  // glitch counts as failed attempt
    addv(1, 1, 0,  3,   0, 1, 0, 0, 0, 1, 1);
    addv(1, 1, 0,  1,   1, 0, 0, 0, 0, 1, 1);
    addv(1, 1, 0,  1,   2, 0, 0, 0, 0, 1, 1);
    addv(1, 1, 0,  6,   2, 0, 0, 0, 0, 1, 1);
    addv(1, 1, 0,  1,   3, 0, 1, 1, 0, 1, 1);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      pll_locked = vq[i].locked;
      restart = vq[i].restart;
      repeat (vq[i].ticks) tick();
      chk($sformatf("v%0d.state", i), int'(state), vq[i].st);
      chk($sformatf("v%0d.pll_rst", i), int'(pll_rst), vq[i].prst);
      chk($sformatf("v%0d.sys_rst_n", i), int'(sys_rst_n), vq[i].srst);
      chk($sformatf("v%0d.ready", i), int'(ready), vq[i].rdy);
      chk($sformatf("v%0d.fail", i), int'(fail), vq[i].fl);
      chk($sformatf("v%0d.retry_cnt", i), int'(retry_cnt), vq[i].rc);
      chk($sformatf("v%0d.loss_cnt", i), int'(loss_cnt), vq[i].lc);
    end
    restart = 1'b0;

    // restart in the same cycle the lock drop reaches the FSM
    pll_locked = 1'b0;
    tick();
    tick();
    chk("coinc.ready_before", int'(ready), 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("coinc.state", int'(state), 0);
    chk("coinc.loss_cnt", int'(loss_cnt), 1);
    chk("coinc.retry_cnt", int'(retry_cnt), 0);
    chk("coinc.ready", int'(ready), 0);
    pll_locked = 1'b1;
    wait_ready(60, "coinc.reseq_ready");

    // repeated loss in RUN; counter must saturate
    exp_loss = 1;
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      tick();
      tick();
      if (k == 0) chk("loss.ready_held", int'(ready), 1);
      tick();
      if (exp_loss < 255) exp_loss++;
      chk($sformatf("loss%0d.loss_cnt", k), int'(loss_cnt), exp_loss);
      if (k == 0) begin
        chk("loss.ready_drop", int'(ready), 0);
        chk("loss.sys_rst_n_drop", int'(sys_rst_n), 0);
        chk("loss.retry_cnt", int'(retry_cnt), 0);
        chk("loss.pll_rst", int'(pll_rst), 1);
      end
      pll_locked = 1'b1;
      wait_ready(40, $sformatf("loss%0d.reseq_ready", k));
    end
    chk("loss.saturated", int'(loss_cnt), 255);

    // async reset while in STABLE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (5) tick();
    chk("arst.pre_state", int'(state), 2);
    chk("arst.pre_pll_rst", int'(pll_rst), 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.state", int'(state), 0);
    chk("arst.pll_rst", int'(pll_rst), 1);
    chk("arst.sys_rst_n", int'(sys_rst_n), 0);
    chk("arst.ready", int'(ready), 0);
    chk("arst.fail", int'(fail), 0);
    chk("arst.retry_cnt", int'(retry_cnt), 0);
    chk("arst.loss_cnt", int'(loss_cnt), 0);
    tick();
    rst_n = 1'b1;
    repeat (11) tick();
    chk("arst.stable_state", int'(state), 2);
    tick();
    chk("arst.run_state", int'(state), 3);
    chk("arst.run_ready", int'(ready), 1);
    chk("arst.run_loss_cnt", int'(loss_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
